// File: rtl/rv32v_wb_buffer_if.sv
// rtl/rv32v_wb_buffer_if.sv - vector writeback buffer bus: upstream push, register-file write port, hazard query
interface rv32v_wb_buffer_if #(
  parameter int NUM_LANES = 2,
  parameter int OFF_W     = 5,
  parameter int VL_WIDTH  = 8
);
  // upstream push side
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_LANES-1:0][31:0] in_data;
  logic [NUM_LANES-1:0]       in_wen;
  logic [4:0]                 in_vd;
  logic [OFF_W-1:0]           in_offset;
  logic [1:0]                 in_eew;
  logic [VL_WIDTH:0]          in_vl;
  logic                       in_single_bit;
  logic                       in_last;

  // control
  logic                       wb_stall;
  logic                       flush;

  // register-file writeback port
  logic [NUM_LANES-1:0][31:0] w_data;
  logic [NUM_LANES-1:0]       wen;
  logic [4:0]                 vd;
  logic [OFF_W-1:0]           vd_offset;
  logic [1:0]                 eew;
  logic [VL_WIDTH:0]          vl;
  logic                       single_bit_write;

  // hazard query and status
  logic [4:0]                 chk_reg;
  logic                       chk_pending;
  logic                       instr_done;
  logic                       busy;

  modport slave (
    input  in_valid, in_data, in_wen, in_vd, in_offset, in_eew, in_vl,
           in_single_bit, in_last, wb_stall, flush, chk_reg,
    output in_ready, w_data, wen, vd, vd_offset, eew, vl, single_bit_write,
           chk_pending, instr_done, busy
  );

  modport master (
    output in_valid, in_data, in_wen, in_vd, in_offset, in_eew, in_vl,
           in_single_bit, in_last, wb_stall, flush, chk_reg,
    input  in_ready, w_data, wen, vd, vd_offset, eew, vl, single_bit_write,
           chk_pending, instr_done, busy
  );
endinterface

// File: rtl/rv32v_wb_buffer.sv
// rtl/rv32v_wb_buffer.sv - FIFO between vector execute results and the register-file write port
module rv32v_wb_buffer #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 4,
  parameter int OFF_W     = 5,
  parameter int VL_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  rv32v_wb_buffer_if.slave     wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [NUM_LANES-1:0][31:0] data;
    logic [NUM_LANES-1:0]       wen;
    logic [4:0]                 vd;
    logic [OFF_W-1:0]           offset;
    logic [1:0]                 eew;
    logic [VL_WIDTH:0]          vl;
    logic                       single_bit;
    logic                       last;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t           head;
  logic             do_pop;
  logic             do_push;
  logic             in_ready;
  logic [PTR_W-1:0] rel_idx;
  logic             pending;

  // Pop/push decisions; a pop is gated by reset so a reset cycle never writes.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    do_pop   = (count_q != '0) && !wb.wb_stall && !wb.flush && nRST;
    in_ready = (count_q < CNT_W'(DEPTH)) || do_pop;
    do_push  = wb.in_valid && in_ready && !wb.flush;
  end

  // Next pointer/count state; flush wins over everything, including a coincident push.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (wb.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Payload write of the incoming entry at the tail slot.
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q].data       = wb.in_data;
      mem_d[wr_ptr_q].wen        = wb.in_wen;
      mem_d[wr_ptr_q].vd         = wb.in_vd;
      mem_d[wr_ptr_q].offset     = wb.in_offset;
      mem_d[wr_ptr_q].eew        = wb.in_eew;
      mem_d[wr_ptr_q].vl         = wb.in_vl;
      mem_d[wr_ptr_q].single_bit = wb.in_single_bit;
      mem_d[wr_ptr_q].last       = wb.in_last;
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are meaningless outside the valid window, so no reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Hazard query: any live entry that will actually write the queried register.
  always_comb begin
    pending = 1'b0;
    rel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel_idx = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, rel_idx} < count_q) && (mem_q[i].vd == wb.chk_reg) &&
          (mem_q[i].wen != '0)) begin
        pending = 1'b1;
      end
    end
  end

  // Writeback port driven straight from the head; all fields zero when not writing.
  always_comb begin
    wb.in_ready         = in_ready;
    wb.busy             = (count_q != '0);
    wb.chk_pending      = pending;
    wb.w_data           = '0;
    wb.wen              = '0;
    wb.vd               = '0;
    wb.vd_offset        = '0;
    wb.eew              = '0;
    wb.vl               = '0;
    wb.single_bit_write = 1'b0;
    wb.instr_done       = 1'b0;
    if (do_pop) begin
      wb.w_data           = head.data;
      wb.wen              = head.wen;
      wb.vd               = head.vd;
      wb.vd_offset        = head.offset;
      wb.eew              = head.eew;
      wb.vl               = head.vl;
      wb.single_bit_write = head.single_bit;
      wb.instr_done       = head.last;
    end
  end

endmodule

// File: tb/tb_rv32v_wb_buffer.sv
// tb/tb_rv32v_wb_buffer.sv - scoreboard bench for rv32v_wb_buffer
module tb_rv32v_wb_buffer;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;
  bit   mon_en;

  rv32v_wb_buffer_if #(.NUM_LANES(2), .OFF_W(5), .VL_WIDTH(8)) wb ();

  rv32v_wb_buffer #(.NUM_LANES(2), .DEPTH(4), .OFF_W(5), .VL_WIDTH(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .wb   (wb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0][31:0] data;
    logic [1:0]       wen;
    logic [4:0]       vd;
    logic [4:0]       off;
    logic [1:0]       eew;
    logic [8:0]       vl;
    logic             sb;
    logic             last;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] vd, input logic [4:0] off,
                              input logic [31:0] d1, input logic [31:0] d0,
                              input logic [1:0] wen, input logic last);
    exp_t e;
    e.data[1] = d1;
    e.data[0] = d0;
    e.wen     = wen;
    e.vd      = vd;
    e.off     = off;
    e.eew     = vd[1:0];
    e.vl      = {4'b0, vd} + {4'b0, off};
    e.sb      = off[0];
    e.last    = last;
    return e;
  endfunction

  task automatic drive(input exp_t e);
    wb.in_valid      = 1'b1;
    wb.in_data       = e.data;
    wb.in_wen        = e.wen;
    wb.in_vd         = e.vd;
    wb.in_offset     = e.off;
    wb.in_eew        = e.eew;
    wb.in_vl         = e.vl;
    wb.in_single_bit = e.sb;
    wb.in_last       = e.last;
  endtask

  task automatic idle_in();
    wb.in_valid      = 1'b0;
    wb.in_data       = '0;
    wb.in_wen        = '0;
    wb.in_vd         = '0;
    wb.in_offset     = '0;
    wb.in_eew        = '0;
    wb.in_vl         = '0;
    wb.in_single_bit = 1'b0;
    wb.in_last       = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  // push one entry that the bench expects to be accepted this cycle
  task automatic push_ok(input string name, input exp_t e);
    drive(e);
    exp_q.push_back(e);
    at_neg();
    chk(name, wb.in_ready, 1);
    step();
    idle_in();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, wb.in_ready, 1);
    chk({tag, "_busy"}, wb.busy, 0);
    chk({tag, "_wen"}, wb.wen, 0);
    chk({tag, "_instr_done"}, wb.instr_done, 0);
    chk({tag, "_chk_pending"}, wb.chk_pending, 0);
    chk({tag, "_w_data"}, wb.w_data, 0);
    chk({tag, "_fields"}, {wb.vd, wb.vd_offset, wb.eew, wb.vl, wb.single_bit_write}, 0);
  endtask

  // monitor: every visible write (wen or instr_done) must match the scoreboard head
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && (wb.wen != 0 || wb.instr_done)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual vd=%0d wen=%0b required no write", wb.vd, wb.wen);
      end else begin
        e = exp_q.pop_front();
        chk("mon_data", wb.w_data, e.data);
        chk("mon_wen", wb.wen, e.wen);
        chk("mon_vd", wb.vd, e.vd);
        chk("mon_off", wb.vd_offset, e.off);
        chk("mon_eew", wb.eew, e.eew);
        chk("mon_vl", wb.vl, e.vl);
        chk("mon_sb", wb.single_bit_write, e.sb);
        chk("mon_done", wb.instr_done, e.last);
      end
    end
  end

  initial begin
    int writes;
    exp_t e;
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    nRST   = 1'b0;
    wb.wb_stall = 1'b0;
    wb.flush    = 1'b0;
    wb.chk_reg  = 5'd0;
    idle_in();
    repeat (3) step();
    nRST = 1'b1;
    mon_en = 1'b1;
    at_neg();
    check_reset_outputs("rst");
    step();

    // single push, one-cycle latency, no bypass
    e = mk(5'd3, 5'd2, 32'hA5A5A5A5, 32'h12345678, 2'b11, 1'b1);
    drive(e);
    exp_q.push_back(e);
    at_neg();
    chk("single_no_bypass", wb.wen, 0);
    chk("single_ready", wb.in_ready, 1);
    step();
    idle_in();
    at_neg();
    chk("single_wen", wb.wen, 2'b11);
    chk("single_vd", wb.vd, 3);
    chk("single_off", wb.vd_offset, 2);
    chk("single_done", wb.instr_done, 1);
    step();
    at_neg();
    chk("single_busy_after", wb.busy, 0);
    step();

    // stalled fill to full, fifth held off, then ordered drain
    wb.wb_stall = 1'b1;
    for (int k = 0; k < 4; k++)
      push_ok("stall_fill_ready", mk(5'(8 + k), 5'(k), 32'h1000 + k, 32'h2000 + k, 2'b11, k[0]));
    e = mk(5'd12, 5'd9, 32'hCAFE0005, 32'hBEEF0005, 2'b10, 1'b1);
    drive(e);
    at_neg();
    chk("full_not_ready", wb.in_ready, 0);
    chk("full_stall_no_wen", wb.wen, 0);
    step();
    wb.wb_stall = 1'b0;
    exp_q.push_back(e);
    for (int j = 0; j < 5; j++) begin
      at_neg();
      if (j == 0) chk("release_ready", wb.in_ready, 1);
      chk("drain_consecutive", (wb.wen != 0), 1);
      step();
      if (j == 0) idle_in();
    end
    at_neg();
    chk("drain_empty", wb.busy, 0);
    step();

    // full with simultaneous push and pop for three cycles (pointers wrap)
    wb.wb_stall = 1'b1;
    for (int k = 0; k < 4; k++)
      push_ok("sp_fill_ready", mk(5'(16 + k), 5'(k + 4), 32'h3000 + k, 32'h4000 + k, 2'b01, 1'b0));
    wb.wb_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = mk(5'(24 + k), 5'(k + 20), 32'h5000 + k, 32'h6000 + k, 2'b11, 1'b1);
      drive(e);
      exp_q.push_back(e);
      at_neg();
      chk("sp_ready", wb.in_ready, 1);
      chk("sp_count", dut.count_q, 4);
      step();
    end
    idle_in();
    at_neg();
    chk("sp_count_after", dut.count_q, 4);
    writes = 0;
    for (int c = 0; c < 10 && wb.busy; c++) begin
      if (wb.wen != 0) writes++;
      step();
      at_neg();
    end
    chk("sp_drain_writes", writes, 4);
    chk("sp_drain_empty", wb.busy, 0);
    step();

    // hazard query
    wb.chk_reg  = 5'd7;
    wb.wb_stall = 1'b1;
    push_ok("haz_ready", mk(5'd7, 5'd1, 32'h0, 32'h77, 2'b01, 1'b1));
    at_neg();
    chk("haz_pending", wb.chk_pending, 1);
    step();
    wb.wb_stall = 1'b0;
    step();
    at_neg();
    chk("haz_after_pop", wb.chk_pending, 0);
    step();
    wb.wb_stall = 1'b1;
    push_ok("haz_nowen_ready", mk(5'd7, 5'd3, 32'h11, 32'h22, 2'b00, 1'b1));
    at_neg();
    chk("haz_nowen_pending", wb.chk_pending, 0);
    step();
    wb.wb_stall = 1'b0;
    at_neg();
    chk("nowen_done", wb.instr_done, 1);
    chk("nowen_wen", wb.wen, 0);
    step();
    at_neg();
    chk("nowen_empty", wb.busy, 0);
    step();
    wb.chk_reg = 5'd0;

    // flush with three buffered, coincident push, stall also high
    wb.wb_stall = 1'b1;
    for (int k = 0; k < 3; k++)
      push_ok("fl_fill_ready", mk(5'(10 + k), 5'(k), 32'h7000 + k, 32'h8000 + k, 2'b11, 1'b1));
    drive(mk(5'd20, 5'd5, 32'hDEAD, 32'hBEEF, 2'b11, 1'b1));
    wb.flush = 1'b1;
    exp_q.delete();
    at_neg();
    chk("flush_no_wen", wb.wen, 0);
    chk("flush_no_done", wb.instr_done, 0);
    step();
    idle_in();
    wb.flush    = 1'b0;
    wb.wb_stall = 1'b0;
    at_neg();
    chk("flush_busy", wb.busy, 0);
    repeat (4) step();

    // reset mid-operation with two buffered entries
    wb.wb_stall = 1'b1;
    for (int k = 0; k < 2; k++)
      push_ok("rst_fill_ready", mk(5'(4 + k), 5'(k + 7), 32'h9000 + k, 32'hA000 + k, 2'b11, 1'b1));
    wb.wb_stall = 1'b0;
    nRST = 1'b0;
    exp_q.delete();
    at_neg();
    chk("rst_no_wen", wb.wen, 0);
    chk("rst_no_done", wb.instr_done, 0);
    step();
    nRST = 1'b1;
    at_neg();
    check_reset_outputs("midrst");
    repeat (4) step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
